// File: rtl/mem_pkg.sv
// Shared memory configuration and arbitration helpers used by the memory and
// its round-robin front-end arbiter.
package mem_pkg;

  // Memory geometry shared by the memory and everything that drives it.
  typedef struct packed {
    int unsigned AWIDTH;
    int unsigned DWIDTH;
  } mem_param;

  localparam mem_param MEM_P_DEFAULT = '{AWIDTH: 4, DWIDTH: 8};

  localparam int unsigned MEM_ARB_MAX_REQ = 8;
  localparam int unsigned MEM_ARB_IDX_W   = 3;

  typedef logic [MEM_ARB_IDX_W-1:0] req_idx_t;

  // Returns the first asserted valid bit at or after ptr, wrapping at nreq.
  // Callers qualify the result with |valid, since an empty vector returns 0.
  function automatic req_idx_t rr_pick(input logic [MEM_ARB_MAX_REQ-1:0] valid,
                                       input req_idx_t                   ptr,
                                       input int unsigned                nreq);
    req_idx_t win;
    logic     found;
    int       idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(MEM_ARB_MAX_REQ); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(nreq)) idx = idx - int'(nreq);
      if (k < int'(nreq) && !found && valid[idx[MEM_ARB_IDX_W-1:0]]) begin
        found = 1'b1;
        win   = req_idx_t'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb.sv
// Round-robin picker: one-hot grant from the valid vector, plus the rotating
// priority pointer that moves just past each winner.
module rr_arb
  import mem_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic            any,
  output req_idx_t        win
);

  req_idx_t rr_ptr_q, rr_ptr_d;

  // Pick the winner and compute the pointer for the next cycle.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves a value held (no latch).
  always_comb begin
    any      = |valid;
    win      = rr_pick(MEM_ARB_MAX_REQ'(valid), rr_ptr_q, NREQ);
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      grant[i] = any && (win == req_idx_t'(i));
    end
    if (any) begin
      rr_ptr_d = (win == req_idx_t'(NREQ - 1)) ? '0 : win + req_idx_t'(1);
    end
  end

  // Priority pointer register; requester 0 has top priority out of reset.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters,
// routing the one-cycle-latency read data back to the owning requester.
// Optional feature macro: MEM_ARB_STATS_EN adds per-requester accept counters
// on output grant_cnt.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter mem_param    P    = MEM_P_DEFAULT,
  parameter int unsigned NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*P.AWIDTH-1:0] req_addr,
  input  logic [NREQ*P.DWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [P.DWIDTH-1:0]      rsp_rdata,
  output logic [P.AWIDTH-1:0]      mem_addr,
  output logic                     mem_wr_en,
  output logic                     mem_rd_en,
  output logic [P.DWIDTH-1:0]      mem_wdata,
  input  logic [P.DWIDTH-1:0]      mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       grant_cnt
`endif
);

  localparam int unsigned AW = P.AWIDTH;
  localparam int unsigned DW = P.DWIDTH;

  logic [NREQ-1:0] valid_gated;
  logic [NREQ-1:0] grant;
  logic            any;
  req_idx_t        win;

  logic     rd_pend_q, rd_pend_d;
  req_idx_t rd_owner_q, rd_owner_d;

  // No grants while reset is held, so all outputs sit at their reset values.
  assign valid_gated = rst ? req_valid : '0;
  assign req_ready   = grant;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (valid_gated),
    .grant (grant),
    .any   (any),
    .win   (win)
  );

  // Steer the winning request onto the memory port and note reads in flight.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        mem_addr  = req_addr[i*AW +: AW];
        mem_wdata = req_wdata[i*DW +: DW];
        mem_wr_en = req_we[i];
        mem_rd_en = !req_we[i];
      end
    end
    rd_pend_d  = any && mem_rd_en;
    rd_owner_d = rd_pend_d ? win : '0;
  end

  // Read-tracking registers: who owns the data the memory returns next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Route the memory read data to the owner as a single-cycle pulse.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rsp_valid[i] = rd_pend_q && (rd_owner_q == req_idx_t'(i));
    end
    rsp_rdata = rd_pend_q ? mem_rdata : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  // Saturating per-requester accept counters.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  // Counter bank register.
  // NOTE: this array is a bank of flops, not a RAM, so every entry is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with NREQ=2 and the default
// 4-bit address / 8-bit data geometry, driving a behavioural one-cycle-latency
// memory. Counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [3:0]  mem_addr;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  logic [7:0] mem_q [16] = '{default: 8'h00};

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp0  = 0;
  int n_rsp1  = 0;

  mem_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port memory: write and read registered on the same edge; rdata is
  // zero in any cycle that follows a non-read.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem_q[mem_addr] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests at the falling edge, then settle.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = 8'h21;
    req_wdata = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state with requests pending.
    check("rst_ready",  32'(req_ready), 32'h0);
    check("rst_rden",   32'(mem_rd_en), 32'h0);
    check("rst_addr",   32'(mem_addr),  32'h0);
    check("rst_rspv",   32'(rsp_valid), 32'h0);
    check("rst_rdata",  32'(rsp_rdata), 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;

    // 1: req0 writes addr 3 <- A5, then reads it back.
    step(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00);
    check("t1_wr_ready", 32'(req_ready), 32'h1);
    check("t1_wr_en",    32'(mem_wr_en), 32'h1);
    check("t1_rd_en",    32'(mem_rd_en), 32'h0);
    check("t1_addr",     32'(mem_addr),  32'h3);
    check("t1_wdata",    32'(mem_wdata), 32'hA5);
    step(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
    check("t1_rd_ready", 32'(req_ready), 32'h1);
    check("t1_rd_rden",  32'(mem_rd_en), 32'h1);
    check("t1_no_wrrsp", 32'(rsp_valid), 32'h0);
    idle();
    check("t1_rspv",     32'(rsp_valid), 32'h1);
    check("t1_rdata",    32'(rsp_rdata), 32'hA5);
    // req1 stores 5A at addr 4 for the fairness run.
    step(2'b10, 2'b10, 4'h0, 4'h4, 8'h00, 8'h5A);
    check("t1_wr1_ready", 32'(req_ready), 32'h2);

    // 2: fairness from a fresh reset, both requesters reading continuously.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 2'b00, 4'h3, 4'h4, 8'h00, 8'h00);
      check("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) begin
        check("t2_rspv",  32'(rsp_valid), (i % 2 == 1) ? 32'h1 : 32'h2);
        check("t2_rdata", 32'(rsp_rdata), (i % 2 == 1) ? 32'hA5 : 32'h5A);
      end
      n_rsp0 += int'(rsp_valid[0]);
      n_rsp1 += int'(rsp_valid[1]);
    end
    idle();
    check("t2_last_rspv",  32'(rsp_valid), 32'h2);
    check("t2_last_rdata", 32'(rsp_rdata), 32'h5A);
    n_rsp0 += int'(rsp_valid[0]);
    n_rsp1 += int'(rsp_valid[1]);
    check("t2_cnt0", 32'(n_rsp0), 32'd4);
    check("t2_cnt1", 32'(n_rsp1), 32'd4);

    // 3: back-to-back reads from req1 (addr 1 = 11, addr 2 = 22).
    step(2'b10, 2'b10, 4'h0, 4'h1, 8'h00, 8'h11);
    step(2'b10, 2'b10, 4'h0, 4'h2, 8'h00, 8'h22);
    step(2'b10, 2'b00, 4'h0, 4'h1, 8'h00, 8'h00);
    check("t3_ready",  32'(req_ready), 32'h2);
    step(2'b10, 2'b00, 4'h0, 4'h2, 8'h00, 8'h00);
    check("t3_rspv_a", 32'(rsp_valid), 32'h2);
    check("t3_rdata_a", 32'(rsp_rdata), 32'h11);
    idle();
    check("t3_rspv_b", 32'(rsp_valid), 32'h2);
    check("t3_rdata_b", 32'(rsp_rdata), 32'h22);
    idle();
    check("t3_rspv_end",  32'(rsp_valid), 32'h0);
    check("t3_rdata_end", 32'(rsp_rdata), 32'h0);

    // 4: read then overlapping write to the same address.
    step(2'b01, 2'b01, 4'h5, 4'h0, 8'h0F, 8'h00);
    step(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00);
    check("t4_rd_ready", 32'(req_ready), 32'h1);
    step(2'b10, 2'b10, 4'h0, 4'h5, 8'h00, 8'hF0);
    check("t4_wr_ready", 32'(req_ready), 32'h2);
    check("t4_wr_en",    32'(mem_wr_en), 32'h1);
    check("t4_rspv",     32'(rsp_valid), 32'h1);
    check("t4_rdata",    32'(rsp_rdata), 32'h0F);
    step(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00);
    check("t4_rd2_ready", 32'(req_ready), 32'h1);
    check("t4_no_wrrsp",  32'(rsp_valid), 32'h0);
    idle();
    check("t4_rspv2",  32'(rsp_valid), 32'h1);
    check("t4_rdata2", 32'(rsp_rdata), 32'hF0);

    // 5: reset arrives while a read response is pending (pointer is 1 here).
    step(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00);
    check("t5_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    #1;
    check("t5_rspv_rst",  32'(rsp_valid), 32'h0);
    check("t5_rdata_rst", 32'(rsp_rdata), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rspv_rel", 32'(rsp_valid), 32'h0);
    step(2'b11, 2'b00, 4'h3, 4'h4, 8'h00, 8'h00);
    check("t5_ptr0",      32'(req_ready), 32'h1);
    check("t5_no_stray",  32'(rsp_valid), 32'h0);
    idle();
    check("t5_rspv",  32'(rsp_valid), 32'h1);
    check("t5_rdata", 32'(rsp_rdata), 32'hA5);

`ifdef MEM_ARB_STATS_EN
    // 6: accept counters, then saturation on req0.
    apply_reset();
    #1;
    check("t6_rst_cnt", grant_cnt, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 2'b01, 4'h0, 4'h0, 8'h01, 8'h00);
      if (i == 0) check("t6_cnt_lag", grant_cnt, 32'h0);
    end
    for (int i = 0; i < 3; i++) step(2'b10, 2'b10, 4'h0, 4'h1, 8'h00, 8'h02);
    idle();
    check("t6_cnt", grant_cnt, {16'd3, 16'd5});
    for (int i = 0; i < 65535; i++) step(2'b01, 2'b01, 4'h0, 4'h0, 8'h03, 8'h00);
    idle();
    check("t6_sat", grant_cnt, {16'd3, 16'hFFFF});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port `memory` instance between `NREQ` requesters. Each requester issues read or write requests over a valid/ready handshake. The arbiter drives the memory's `addr`/`wr_en`/`rd_en`/`wdata` ports, tracks which requester owns each outstanding read, and routes the one-cycle-latency read data back as a response pulse. It sits directly in front of `memory`, and the two share the same `mem_pkg::mem_param` configuration.

## Interface
Parameters:
- `P`, default `mem_pkg::MEM_P_DEFAULT`: memory geometry; uses `P.AWIDTH` and `P.DWIDTH`.
- `NREQ`, default 2: number of requesters, 2..8.

Ports:
- `clk`  in  1  clock; every register is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NREQ`  per-requester request valid.
- `req_we`  in  `NREQ`  1 = write, 0 = read.
- `req_addr`  in  `NREQ`×`P.AWIDTH`  per-requester address.
- `req_wdata`  in  `NREQ`×`P.DWIDTH`  per-requester write data.
- `req_ready`  out  `NREQ`  one-hot grant; a request is accepted when valid and ready are both high.
- `rsp_valid`  out  `NREQ`  one-cycle read-response pulse to the owning requester.
- `rsp_rdata`  out  `P.DWIDTH`  read data, shared by all requesters; meaningful only when a `rsp_valid` bit is high.
- `mem_addr`  out  `P.AWIDTH`  to memory `addr`.
- `mem_wr_en`  out  1  to memory `wr_en`.
- `mem_rd_en`  out  1  to memory `rd_en`.
- `mem_wdata`  out  `P.DWIDTH`  to memory `wdata`.
- `mem_rdata`  in  `P.DWIDTH`  from memory `rdata`.

## Operation
- **Arbitration.** Each cycle the arbiter picks at most one winner from the asserted `req_valid` bits. The search is round-robin, starting at pointer `rr_ptr`.
- **Outputs for the winner.** `req_ready[w]`=1 and all other `req_ready` bits are 0. `mem_addr`, `mem_wdata` and `mem_wr_en`=`req_we[w]` come from the winner, and `mem_rd_en`=!`req_we[w]`.
- **Outputs with no winner.** `req_ready`=0, `mem_wr_en`=0, `mem_rd_en`=0, `mem_addr`=0, `mem_wdata`=0.
- **Grant and memory drive are combinational** from `req_valid` and `rr_ptr`. `req_ready` never depends on `req_ready`, so there is no combinational loop.
- **Pointer update.** On an accept, `rr_ptr` ← (w+1) mod `NREQ`. With no accept, `rr_ptr` holds its value.
- **Read tracking.** On a read accept, register `rd_pend`=1 and `rd_owner`=w for the next cycle. Otherwise `rd_pend`=0.
- **Read response.** While `rd_pend`=1, `rsp_valid[rd_owner]`=1 and `rsp_rdata`=`mem_rdata`. At all other times `rsp_valid`=0 and `rsp_rdata`=0.
- **No response backpressure.** The requester must capture the response in the pulse cycle.
- **Write accepts** produce no response.
- **Ordering** is strictly accept order. A read accepted the cycle after a write to the same address returns the new data.
- **Request stability.** A requester holds `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until accepted.
- **Fairness.** With all requesters continuously valid, each is granted exactly once every `NREQ` cycles.

## Timing
- **Reset values.** `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, all `mem_*` outputs=0, `rr_ptr`=0, `rd_pend`=0, `rd_owner`=0.
- **Accept latency.** An accept in cycle T drives the memory in the same cycle T.
- **Read latency.** A read accepted in cycle T gives a `rsp_valid` pulse in cycle T+1. Data is `mem_rdata` as registered by the memory at the end of cycle T.
- **Throughput.** One access per cycle. Back-to-back reads give back-to-back responses.
- **Write in the response cycle.** A write accepted in T+1 does not corrupt the T+1 response. The memory clears its `rdata` only at the end of T+1.
- **Reset mid-operation.** A pending read response is dropped; no pulse is issued after reset deasserts.
- **First cycle out of reset.** Arbitration is normal, with requester 0 at highest priority.

## Configuration
- Macro: `MEM_ARB_STATS_EN`.
- **Defined:** adds output `grant_cnt` (`NREQ`×16).
  - Per-requester count of accepted requests.
  - Resets to 0.
  - Saturates at 16'hFFFF.
  - Increments in the cycle after the accept.
- **Undefined:** the port and its counters are absent; all other behaviour is identical.

## Structure
- **Shared package `mem_pkg`:**
  - existing `mem_param` struct;
  - new `MEM_P_DEFAULT` constant (`AWIDTH`=4, `DWIDTH`=8);
  - `MEM_ARB_MAX_REQ`=8;
  - function `rr_pick(valid, ptr)` returning the winner index.
- **Sub-module `rr_arb`:** the pure round-robin picker, holding `rr_ptr` and the pointer update. It is natural to split out because the top level only adds memory drive and response routing.

## Test plan
1. **Single-requester write then read.** Req0 writes addr 3, data 8'hA5; next cycle req0 reads addr 3 → `rsp_valid[0]` the cycle after the read accept, `rsp_rdata`=8'hA5.
2. **Round-robin fairness.** `NREQ`=2, both requesters continuously issue reads for 8 cycles → grants alternate 0,1,0,1…; each requester receives 4 responses, each in the cycle after its own accept.
3. **Back-to-back reads.** Req1 reads addr 1 then addr 2, holding 8'h11 and 8'h22 → consecutive pulses on `rsp_valid[1]` with 8'h11 then 8'h22.
4. **Read followed by write.** Req0 reads addr 5 (8'h0F) in T; req1 writes addr 5 ← 8'hF0 in T+1 → T+1 response is 8'h0F to req0; a read of addr 5 afterwards returns 8'hF0.
5. **Reset during pending read.** Assert `rst` low in the cycle after a read accept → `rsp_valid`=0; after release, `rr_ptr`=0 and no stray response appears.
6. **Stats (`MEM_ARB_STATS_EN` defined).** 5 accepts on req0 and 3 on req1 → `grant_cnt` = {3,5}; a 16'hFFFF saturation check is forced via long run.
